// File: rtl/secded_decoder_pipe.sv
// Pipelined, parametrised SEC-DED decoder (extended Hamming code).
// S1 computes the syndrome and overall parity of the received word, and
// S2 classifies the word and corrects it. A single global stall holds both
// stages while the consumer is not ready. Two saturating counters track
// corrected and uncorrectable events.
module secded_decoder_pipe #(
   parameter int  DATA_W     = 32,
   parameter int  ENABLE_DED = 1,
   parameter int  CNT_W      = 16,
   localparam int CHK_W      = $clog2(DATA_W + $clog2(DATA_W) + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CHK_W:0]    in_chk,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sbe,
   output logic              out_dbe,
   output logic [CHK_W-1:0]  out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  sbe_cnt,
   output logic [CNT_W-1:0]  dbe_cnt
);

   localparam int N_POS = DATA_W + CHK_W;

   // Codeword position of data bit idx: the idx-th position that is not a power of two.
   function automatic int data_pos(input int idx);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int pos = 1; pos <= N_POS; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (cnt == idx) res = pos;
            cnt++;
         end
      end
      return res;
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic              advance;
   logic [CHK_W-1:0]  syn_c;
   logic              par_c;
   logic              vld_p1;
   logic [CHK_W-1:0]  syn_p1;
   logic              par_p1;
   logic [DATA_W-1:0] data_p1;
   logic              in_range;
   logic [DATA_W-1:0] data_c;
   logic              sbe_c;
   logic              dbe_c;
   logic              vld_p2;
   logic [DATA_W-1:0] data_p2;
   logic              sbe_p2;
   logic              dbe_p2;
   logic [CHK_W-1:0]  syn_p2;

   assign advance      = !vld_p2 || out_ready;
   assign in_ready     = advance;
   assign out_valid    = vld_p2;
   assign out_data     = data_p2;
   assign out_sbe      = sbe_p2;
   assign out_dbe      = dbe_p2;
   assign out_syndrome = syn_p2;

   // Syndrome: check bits sit at positions 2^i, so they contribute bit i directly.
   always_comb begin
      syn_c = in_chk[CHK_W-1:0];
      for (int j = 0; j < DATA_W; j++) begin
         if (in_data[j]) syn_c = syn_c ^ CHK_W'(data_pos(j));
      end
      par_c = (ENABLE_DED != 0) ? (^in_data ^ ^in_chk) : 1'b0;
   end

   // ---- S1: syndrome, parity, raw data ----
   // Stage-1 valid is control and is cleared by reset.
   always_ff @(posedge clk) begin
      if (rst)          vld_p1 <= 1'b0;
      else if (advance) vld_p1 <= in_valid;
   end

   // Stage-1 datapath registers follow the global stall only.
   always_ff @(posedge clk) begin
      if (advance) begin
         syn_p1  <= syn_c;
         par_p1  <= par_c;
         data_p1 <= in_data;
      end
   end

   // Classify the word and flip the addressed data bit on a correctable error.
   always_comb begin
      data_c   = data_p1;
      sbe_c    = 1'b0;
      dbe_c    = 1'b0;
      in_range = int'(syn_p1) <= N_POS;
      if (ENABLE_DED != 0) begin
         if (par_p1) begin
            if (in_range) sbe_c = 1'b1;
            else          dbe_c = 1'b1;
         end else if (syn_p1 != '0) begin
            dbe_c = 1'b1;
         end
      end else if (syn_p1 != '0) begin
         if (in_range) sbe_c = 1'b1;
         else          dbe_c = 1'b1;
      end
      // A zero or power-of-two syndrome matches no data position, so data passes unchanged.
      if (sbe_c) begin
         for (int j = 0; j < DATA_W; j++) begin
            if (data_pos(j) == int'(syn_p1)) data_c[j] = ~data_p1[j];
         end
      end
   end

   // ---- S2: corrected data and flags, visible on the outputs ----
   // Output stage; reset clears the visible word so nothing stale is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         data_p2 <= '0;
         sbe_p2  <= 1'b0;
         dbe_p2  <= 1'b0;
         syn_p2  <= '0;
      end else if (advance) begin
         vld_p2  <= vld_p1;
         data_p2 <= data_c;
         sbe_p2  <= sbe_c;
         dbe_p2  <= dbe_c;
         syn_p2  <= syn_p1;
      end
   end

   // Error-event counters count on output transfer; clear wins over a same-cycle event.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         sbe_cnt <= '0;
         dbe_cnt <= '0;
      end else begin
         if (vld_p2 && out_ready && sbe_p2) sbe_cnt <= sat_inc(sbe_cnt);
         if (vld_p2 && out_ready && dbe_p2) dbe_cnt <= sat_inc(dbe_cnt);
      end
   end

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed bench for secded_decoder_pipe: SEC-DED, SEC-only and 2-bit-counter instances share stimulus.
module tb_secded_decoder_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        cnt_clr;
   logic [31:0] in_data;
   logic [6:0]  in_chk;

   logic        d_in_ready, d_out_valid, d_out_sbe, d_out_dbe;
   logic [31:0] d_out_data;
   logic [5:0]  d_out_syn;
   logic [15:0] d_sbe_cnt, d_dbe_cnt;

   logic        s_in_ready, s_out_valid, s_out_sbe, s_out_dbe;
   logic [31:0] s_out_data;
   logic [5:0]  s_out_syn;
   logic [15:0] s_sbe_cnt, s_dbe_cnt;

   logic        t_in_ready, t_out_valid, t_out_sbe, t_out_dbe;
   logic [31:0] t_out_data;
   logic [5:0]  t_out_syn;
   logic [1:0]  t_sbe_cnt, t_dbe_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] words [5] = '{32'hA5A5_0000, 32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0000, 32'h1234_5678};

   always #5 clk = ~clk;

   secded_decoder_pipe #(.DATA_W(32), .ENABLE_DED(1), .CNT_W(16)) u_ded (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
      .in_chk(in_chk), .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
      .out_sbe(d_out_sbe), .out_dbe(d_out_dbe), .out_syndrome(d_out_syn), .cnt_clr(cnt_clr),
      .sbe_cnt(d_sbe_cnt), .dbe_cnt(d_dbe_cnt));

   secded_decoder_pipe #(.DATA_W(32), .ENABLE_DED(0), .CNT_W(16)) u_sec (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .in_chk(in_chk), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_sbe(s_out_sbe), .out_dbe(s_out_dbe), .out_syndrome(s_out_syn), .cnt_clr(cnt_clr),
      .sbe_cnt(s_sbe_cnt), .dbe_cnt(s_dbe_cnt));

   secded_decoder_pipe #(.DATA_W(32), .ENABLE_DED(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
      .in_chk(in_chk), .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
      .out_sbe(t_out_sbe), .out_dbe(t_out_dbe), .out_syndrome(t_out_syn), .cnt_clr(cnt_clr),
      .sbe_cnt(t_sbe_cnt), .dbe_cnt(t_dbe_cnt));

   // Reference encoder: check bit i = XOR of data positions with bit i set; bit 6 = overall parity.
   function automatic logic [6:0] encode(input logic [31:0] d);
      logic [5:0] s;
      int k;
      s = '0;
      k = 0;
      for (int pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (d[k]) s = s ^ pos[5:0];
            k++;
         end
      end
      return {^d ^ ^s, s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      in_data = '0; in_chk = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({d_out_valid, d_out_sbe, d_out_dbe, d_in_ready} !== 4'b0001) begin
         n_err++; $display("FAIL reset_ctrl got=%b exp=0001", {d_out_valid, d_out_sbe, d_out_dbe, d_in_ready});
      end
      n_cmp++;
      if ({d_out_data, d_out_syn, d_sbe_cnt, d_dbe_cnt} !== 70'd0) begin
         n_err++; $display("FAIL reset_data got=%h exp=0", {d_out_data, d_out_syn, d_sbe_cnt, d_dbe_cnt});
      end
   endtask

   task automatic test_clean();
      do_reset();
      in_data = 32'hA5A5_0000; in_chk = encode(32'hA5A5_0000); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (d_out_valid !== 1'b0) begin
         n_err++; $display("FAIL clean_latency1 got=%b exp=0", d_out_valid);
      end
      step();
      n_cmp++;
      if ({d_out_valid, d_out_sbe, d_out_dbe, d_out_syn, d_out_data} !== {3'b100, 6'd0, 32'hA5A5_0000}) begin
         n_err++; $display("FAIL clean_out got=%b/%h exp=100000000/a5a50000",
                           {d_out_valid, d_out_sbe, d_out_dbe, d_out_syn}, d_out_data);
      end
      step();
      n_cmp++;
      if ({d_out_valid, d_sbe_cnt, d_dbe_cnt} !== 33'd0) begin
         n_err++; $display("FAIL clean_after got=%h exp=0", {d_out_valid, d_sbe_cnt, d_dbe_cnt});
      end
   endtask

   task automatic test_single();
      logic [31:0] vd [4] = '{32'h1, 32'h0, 32'h0, 32'h8000_0000};
      logic [6:0]  vc [4] = '{7'h00, 7'h04, 7'h40, 7'h00};
      logic [5:0]  vs [4] = '{6'd3, 6'd4, 6'd0, 6'd38};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         in_data = vd[i]; in_chk = vc[i]; in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         step();
         n_cmp++;
         if ({d_out_valid, d_out_sbe, d_out_dbe, d_out_syn, d_out_data} !== {3'b110, vs[i], 32'h0}) begin
            n_err++; $display("FAIL single_%0d got=%b syn=%0d data=%h exp=110 syn=%0d data=0",
                              i, {d_out_valid, d_out_sbe, d_out_dbe}, d_out_syn, d_out_data, vs[i]);
         end
      end
      step();
      n_cmp++;
      if ({d_sbe_cnt, d_dbe_cnt} !== {16'd4, 16'd0}) begin
         n_err++; $display("FAIL single_cnt got=%0d/%0d exp=4/0", d_sbe_cnt, d_dbe_cnt);
      end
      // SEC-only ignores the overall-parity bit, so the 0x40 word is clean there.
      n_cmp++;
      if (s_sbe_cnt !== 16'd3) begin
         n_err++; $display("FAIL sec_single_cnt got=%0d exp=3", s_sbe_cnt);
      end
   endtask

   task automatic test_double();
      do_reset();
      in_data = 32'h3; in_chk = 7'h00; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      n_cmp++;
      if ({d_out_sbe, d_out_dbe, d_out_syn, d_out_data} !== {2'b01, 6'd6, 32'h3}) begin
         n_err++; $display("FAIL double_ded got=%b syn=%0d data=%h exp=01 syn=6 data=3",
                           {d_out_sbe, d_out_dbe}, d_out_syn, d_out_data);
      end
      n_cmp++;
      if ({s_out_sbe, s_out_dbe, s_out_syn, s_out_data} !== {2'b10, 6'd6, 32'h7}) begin
         n_err++; $display("FAIL double_sec got=%b syn=%0d data=%h exp=10 syn=6 data=7",
                           {s_out_sbe, s_out_dbe}, s_out_syn, s_out_data);
      end
      // Syndrome 63 lies beyond the last codeword position (38).
      in_data = 32'h0; in_chk = 7'h7F; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      n_cmp++;
      if ({d_out_sbe, d_out_dbe, d_out_syn, d_out_data} !== {2'b01, 6'd63, 32'h0}) begin
         n_err++; $display("FAIL range_ded got=%b syn=%0d data=%h exp=01 syn=63 data=0",
                           {d_out_sbe, d_out_dbe}, d_out_syn, d_out_data);
      end
      n_cmp++;
      if ({s_out_sbe, s_out_dbe} !== 2'b01) begin
         n_err++; $display("FAIL range_sec got=%b exp=01", {s_out_sbe, s_out_dbe});
      end
      step();
      n_cmp++;
      if ({d_dbe_cnt, s_dbe_cnt, d_sbe_cnt} !== {16'd2, 16'd1, 16'd0}) begin
         n_err++; $display("FAIL double_cnt got=%0d/%0d/%0d exp=2/1/0", d_dbe_cnt, s_dbe_cnt, d_sbe_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int recv = 0;
      int stalls = 0;
      logic held_v = 1'b0;
      logic [31:0] held_d = '0;
      logic acc;
      do_reset();
      for (int c = 0; c < 40 && recv < 5; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         in_valid  = (sent < 5);
         in_data   = words[(sent < 5) ? sent : 0];
         in_chk    = encode(in_data);
         #1;
         if (held_v) begin
            n_cmp++;
            if (d_out_data !== held_d) begin
               n_err++; $display("FAIL bp_stable c=%0d got=%h exp=%h", c, d_out_data, held_d);
            end
         end
         if (d_out_valid && !out_ready) begin
            stalls++;
            n_cmp++;
            if (d_in_ready !== 1'b0) begin
               n_err++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, d_in_ready);
            end
            held_v = 1'b1;
            held_d = d_out_data;
         end else begin
            held_v = 1'b0;
         end
         if (d_out_valid && out_ready) begin
            n_cmp++;
            if ({d_out_sbe, d_out_dbe, d_out_data} !== {2'b00, words[recv]}) begin
               n_err++; $display("FAIL bp_word_%0d got=%b/%h exp=00/%h", recv, {d_out_sbe, d_out_dbe},
                                 d_out_data, words[recv]);
            end
            recv++;
         end
         acc = in_valid && d_in_ready;
         step();
         if (acc) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_cmp++;
      if ({sent, recv, stalls} !== {32'd5, 32'd5, 32'd3}) begin
         n_err++; $display("FAIL bp_counts sent=%0d recv=%0d stalls=%0d exp=5/5/3", sent, recv, stalls);
      end
      step();
      n_cmp++;
      if (d_out_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_drain got=%b exp=0", d_out_valid);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      in_data = 32'h1; in_chk = 7'h00; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) step();
      in_valid = 1'b0;
      step(); step();
      n_cmp++;
      if ({t_sbe_cnt, d_sbe_cnt} !== {2'd3, 16'd5}) begin
         n_err++; $display("FAIL sat_cnt got=%0d/%0d exp=3/5", t_sbe_cnt, d_sbe_cnt);
      end
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      cnt_clr = 1'b1;
      n_cmp++;
      if ({t_out_valid, t_out_sbe} !== 2'b11) begin
         n_err++; $display("FAIL clr_setup got=%b exp=11", {t_out_valid, t_out_sbe});
      end
      step();
      cnt_clr = 1'b0;
      n_cmp++;
      if ({t_sbe_cnt, d_sbe_cnt} !== {2'd0, 16'd0}) begin
         n_err++; $display("FAIL clr_priority got=%0d/%0d exp=0/0", t_sbe_cnt, d_sbe_cnt);
      end
   endtask

   task automatic test_midreset();
      do_reset();
      in_data = 32'h1; in_chk = 7'h00; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      n_cmp++;
      if (d_sbe_cnt !== 16'd1) begin
         n_err++; $display("FAIL mid_pre_cnt got=%0d exp=1", d_sbe_cnt);
      end
      in_data = 32'h2; in_valid = 1'b1;
      step();
      in_data = 32'h4;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({d_out_valid, d_sbe_cnt, d_dbe_cnt, d_out_data} !== 65'd0) begin
         n_err++; $display("FAIL mid_reset got=v%b cnt=%0d/%0d data=%h exp=0",
                           d_out_valid, d_sbe_cnt, d_dbe_cnt, d_out_data);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (d_out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_stale_%0d got=%b exp=0", i, d_out_valid);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean();
      test_single();
      test_double();
      test_back_to_back();
      test_saturate();
      test_midreset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
